// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
`timescale 1ns/100ps
package freq_div_pkg;

    localparam int FREQ_DIV_MIN = 2;
    localparam int DIV_DEFAULT  = 10;

    // Counter width for a modulo-div counter; never narrower than one bit.
    function automatic int cnt_width(input int div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/freq_divider_if.sv
// Output bundle of the clock divider: divided clock plus counter observability.
`timescale 1ns/100ps
interface freq_divider_if
    import freq_div_pkg::*;
#(
    parameter int CNT_W = cnt_width(DIV_DEFAULT)
);
    logic             clk_out;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             half;

    modport master (output clk_out, cnt, wrap, half);
    modport slave  (input  clk_out, cnt, wrap, half);
endinterface

// File: rtl/freq_div_cnt.sv
// Modulo-DIV counter with strobes marking the last count (wrap) and the
// count just before the half-period point (half).
`timescale 1ns/100ps
module freq_div_cnt
    import freq_div_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             half
);

    localparam int               K         = DIV / 2;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(K - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        wrap  = (cnt_q == LAST);
        half  = (cnt_q == HALF_LAST);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/freq_divider.sv
// Integer clock divider: clk_out period = DIV x clk_in period, forced low by reset.
// Define FREQ_DIV_DUTY50_EN to get 50 % duty for odd DIV via a falling-edge stage.
`timescale 1ns/100ps
module freq_divider
    import freq_div_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic           clk_in,
    input  logic           reset,
    freq_divider_if.master out_if
);

    generate
        if (DIV < FREQ_DIV_MIN) begin : g_div_too_small
            $error("freq_divider: DIV=%0d is below the minimum of %0d", DIV, FREQ_DIV_MIN);
        end
        if (CNT_W != cnt_width(DIV)) begin : g_cnt_w_overridden
            $error("freq_divider: CNT_W=%0d does not match DIV=%0d", CNT_W, DIV);
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             half;
    logic             pos_q;
    logic             pos_d;
    logic             clk_out;

    freq_div_cnt #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_in (clk_in),
        .reset  (reset),
        .cnt    (cnt),
        .wrap   (wrap),
        .half   (half)
    );

    // For DIV == 2 both strobes alternate, so the phase toggles every edge.
    always_comb begin
        pos_d = pos_q ^ (wrap | half);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pos_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
        end
    end

`ifdef FREQ_DIV_DUTY50_EN
    generate
        if (DIV % 2 == 1) begin : g_duty50
            logic neg_q;
            logic neg_d;

            always_comb begin
                neg_d = pos_q;
            end

            always_ff @(negedge clk_in or posedge reset) begin
                if (reset) begin
                    neg_q <= 1'b0;
                end else begin
                    neg_q <= neg_d;
                end
            end

            // Rising edge delayed half a cycle, falling edge kept on the posedge.
            assign clk_out = pos_q & neg_q;
        end else begin : g_plain
            assign clk_out = pos_q;
        end
    endgenerate
`else
    assign clk_out = pos_q;
`endif

    assign out_if.clk_out = clk_out;
    assign out_if.cnt     = cnt;
    assign out_if.wrap    = wrap;
    assign out_if.half    = half;

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider with DIV = 10, 2 and 5 on a 4 ns clock.
`timescale 1ns/100ps
module tb_freq_divider;
    import freq_div_pkg::*;

`ifdef FREQ_DIV_DUTY50_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst10 = 1'b1;
    logic rst2  = 1'b1;
    logic rst5  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Rising edges at 2, 6, 10, ... so reset edges at multiples of 4 never race the clock.
    always #2 clk = ~clk;

    freq_divider_if #(.CNT_W(4)) if10 ();
    freq_divider_if #(.CNT_W(1)) if2  ();
    freq_divider_if #(.CNT_W(3)) if5  ();

    freq_divider #(.DIV(10)) dut10 (.clk_in(clk), .reset(rst10), .out_if(if10));
    freq_divider #(.DIV(2))  dut2  (.clk_in(clk), .reset(rst2),  .out_if(if2));
    freq_divider #(.DIV(5))  dut5  (.clk_in(clk), .reset(rst5),  .out_if(if5));

    // Expected clk_out after n rising edges since reset release, sampled just
    // after the posedge (after_neg=0) or just after the following negedge.
    function automatic bit exp_out(input int div, input int n, input bit after_neg, input bit duty);
        int k;
        int m;
        int mp;
        k  = div / 2;
        m  = n % div;
        mp = (n - 1) % div;
        if (!duty || after_neg) begin
            return m >= k;
        end
        return (m >= k) && (mp >= k);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (if10.clk_out !== 1'b0 || if10.cnt !== 4'd0) begin
                bad++;
                $display("FAIL reset_div10 t=%0t: clk_out=%b cnt=%0d, want 0/0", $time, if10.clk_out, if10.cnt);
            end
            total++;
            if (if2.clk_out !== 1'b0 || if5.clk_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_others t=%0t: div2=%b div5=%b, want 0/0", $time, if2.clk_out, if5.clk_out);
            end
        end
        #1;
        rst10 = 1'b0;
        $display("test_reset: reset released at t=%0t", $time);
    endtask

    task automatic test_div10_seq(input string tag, input int nedges);
        time first_edge;
        time t_edge;
        time rise1;
        time rise2;
        time fall1;
        bit  prev;
        bit  cur;
        bit  e;
        int  m;
        first_edge = 0;
        rise1 = 0;
        rise2 = 0;
        fall1 = 0;
        prev  = 1'b0;
        for (int n = 1; n <= nedges; n++) begin
            @(posedge clk);
            t_edge = $time;
            if (n == 1) first_edge = t_edge;
            #1;
            m = n % 10;
            total++;
            if (if10.cnt !== 4'(m)) begin
                bad++;
                $display("FAIL %s cnt edge %0d: got %0d want %0d", tag, n, if10.cnt, m);
            end
            total++;
            if (if10.wrap !== (m == 9) || if10.half !== (m == 4)) begin
                bad++;
                $display("FAIL %s strobes edge %0d: wrap=%b half=%b want %b %b", tag, n, if10.wrap, if10.half, m == 9, m == 4);
            end
            e = exp_out(10, n, 1'b0, 1'b0);
            total++;
            if (if10.clk_out !== e) begin
                bad++;
                $display("FAIL %s clk_out edge %0d: got %b want %b", tag, n, if10.clk_out, e);
            end
            cur = (if10.clk_out === 1'b1);
            if (cur && !prev) begin
                if (rise1 == 0) rise1 = t_edge;
                else if (rise2 == 0) rise2 = t_edge;
            end
            if (!cur && prev && rise1 != 0 && fall1 == 0) fall1 = t_edge;
            prev = cur;
            @(negedge clk);
            #1;
            e = exp_out(10, n, 1'b1, 1'b0);
            total++;
            if (if10.clk_out !== e) begin
                bad++;
                $display("FAIL %s clk_out mid-cycle %0d: got %b want %b", tag, n, if10.clk_out, e);
            end
        end
        // First rise lands on edge K=5, i.e. four periods after the first edge.
        total++;
        if (int'(rise1 - first_edge) != 16) begin
            bad++;
            $display("FAIL %s first_rise: got %0d ns after first edge, want 16", tag, int'(rise1 - first_edge));
        end
        total++;
        if (int'(rise2 - rise1) != 40) begin
            bad++;
            $display("FAIL %s period: got %0d ns want 40", tag, int'(rise2 - rise1));
        end
        total++;
        if (int'(fall1 - rise1) != 20) begin
            bad++;
            $display("FAIL %s high_time: got %0d ns want 20", tag, int'(fall1 - rise1));
        end
        $display("test_div10_seq %s: %0d edges from t=%0t", tag, nedges, first_edge);
    endtask

    task automatic test_mid_reset();
        // Entered just after the 29th edge, while clk_out is high.
        total++;
        if (if10.clk_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset precondition: clk_out=%b want 1", if10.clk_out);
        end
        #0.5;
        rst10 = 1'b1;
        #0.1;
        total++;
        if (if10.clk_out !== 1'b0 || if10.cnt !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset async: clk_out=%b cnt=%0d want 0/0", if10.clk_out, if10.cnt);
        end
        while ($realtime < 319.0) begin
            @(posedge clk);
            #1;
            total++;
            if (if10.clk_out !== 1'b0 || if10.cnt !== 4'd0) begin
                bad++;
                $display("FAIL mid_reset hold t=%0t: clk_out=%b cnt=%0d want 0/0", $time, if10.clk_out, if10.cnt);
            end
        end
        #1;
        rst10 = 1'b0;
        $display("test_mid_reset: reset re-released at t=%0t", $time);
        test_div10_seq("after_mid_reset", 24);
    endtask

    task automatic test_reset_held();
        int viol;
        #3;
        rst10 = 1'b1;
        #0.1;
        total++;
        if (if10.clk_out !== 1'b0 || if10.cnt !== 4'd0) begin
            bad++;
            $display("FAIL held_async: clk_out=%b cnt=%0d want 0/0", if10.clk_out, if10.cnt);
        end
        viol = 0;
        repeat (2500) begin
            @(posedge clk);
            #1;
            if (if10.clk_out !== 1'b0 || if10.cnt !== 4'd0) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL held_10us: %0d nonzero samples, want 0", viol);
        end
        $display("test_reset_held: held until t=%0t", $time);
    endtask

    task automatic test_div2();
        time first_edge;
        time t_edge;
        time rise1;
        time rise2;
        bit  prev;
        bit  cur;
        bit  e;
        first_edge = 0;
        rise1 = 0;
        rise2 = 0;
        prev  = 1'b0;
        @(negedge clk);
        rst2 = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            t_edge = $time;
            if (n == 1) first_edge = t_edge;
            #1;
            total++;
            if (if2.cnt !== 1'(n % 2)) begin
                bad++;
                $display("FAIL div2 cnt edge %0d: got %0d want %0d", n, if2.cnt, n % 2);
            end
            e = exp_out(2, n, 1'b0, 1'b0);
            total++;
            if (if2.clk_out !== e) begin
                bad++;
                $display("FAIL div2 clk_out edge %0d: got %b want %b", n, if2.clk_out, e);
            end
            cur = (if2.clk_out === 1'b1);
            if (cur && !prev) begin
                if (rise1 == 0) rise1 = t_edge;
                else if (rise2 == 0) rise2 = t_edge;
            end
            prev = cur;
        end
        total++;
        if (int'(rise1 - first_edge) != 0 || int'(rise2 - rise1) != 8) begin
            bad++;
            $display("FAIL div2 timing: first rise +%0d ns period %0d ns, want +0 and 8",
                     int'(rise1 - first_edge), int'(rise2 - rise1));
        end
        $display("test_div2: 8 edges from t=%0t", first_edge);
    endtask

    task automatic test_div5();
        time first_edge;
        time t_edge;
        time rise1;
        time rise2;
        time fall1;
        bit  prev;
        bit  cur;
        bit  e;
        int  m;
        int  want_rise;
        int  want_high;
        first_edge = 0;
        rise1 = 0;
        rise2 = 0;
        fall1 = 0;
        prev  = 1'b0;
        want_rise = DUTY ? 6 : 4;
        want_high = DUTY ? 10 : 12;
        @(negedge clk);
        rst5 = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            for (int ph = 0; ph < 2; ph++) begin
                if (ph == 0) @(posedge clk);
                else @(negedge clk);
                t_edge = $time;
                if (n == 1 && ph == 0) first_edge = t_edge;
                #1;
                m = n % 5;
                if (ph == 0) begin
                    total++;
                    if (if5.cnt !== 3'(m) || if5.wrap !== (m == 4) || if5.half !== (m == 1)) begin
                        bad++;
                        $display("FAIL div5 cnt edge %0d: cnt=%0d wrap=%b half=%b want %0d %b %b",
                                 n, if5.cnt, if5.wrap, if5.half, m, m == 4, m == 1);
                    end
                end
                e = exp_out(5, n, ph == 1, DUTY);
                total++;
                if (if5.clk_out !== e) begin
                    bad++;
                    $display("FAIL div5 clk_out edge %0d phase %0d: got %b want %b", n, ph, if5.clk_out, e);
                end
                cur = (if5.clk_out === 1'b1);
                if (cur && !prev) begin
                    if (rise1 == 0) rise1 = t_edge;
                    else if (rise2 == 0) rise2 = t_edge;
                end
                if (!cur && prev && rise1 != 0 && fall1 == 0) fall1 = t_edge;
                prev = cur;
            end
        end
        total++;
        if (int'(rise1 - first_edge) != want_rise) begin
            bad++;
            $display("FAIL div5 first_rise: got +%0d ns want +%0d", int'(rise1 - first_edge), want_rise);
        end
        total++;
        if (int'(fall1 - rise1) != want_high) begin
            bad++;
            $display("FAIL div5 high_time: got %0d ns want %0d", int'(fall1 - rise1), want_high);
        end
        total++;
        if (int'(rise2 - rise1) != 20) begin
            bad++;
            $display("FAIL div5 period: got %0d ns want 20", int'(rise2 - rise1));
        end
        $display("test_div5: duty50=%0d, 15 edges from t=%0t", DUTY, first_edge);
    endtask

    initial begin
        test_reset();
        test_div10_seq("first_release", 29);
        test_mid_reset();
        test_reset_held();
        test_div2();
        test_div5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
